shift_issue_stage: RTL and testbench
====================================

# shift_issue_stage

Two-stage valid/ready pipeline that sits directly upstream of the 32-bit bidirectional logical shifter in the execute path. It decodes the shift opcode, selects the shift amount (immediate or register), and drives the shifter's operand, amount and direction inputs. It then registers the shifter output together with arithmetic-right sign fill, carry-out and zero/sign flags for the writeback stage.

## Interface
Parameters
- none; data width fixed at 32, shift amount 5 bits.

Ports
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream has a shift instruction.
- in_ready  out  1  stage can accept this cycle.
- in_op  in  3  000 shll, 001 shrl, 010 shra, 100 shllv, 101 shrlv, 110 shrav; 011 and 111 are illegal.
- in_rs  in  32  operand to shift.
- in_rt  in  32  variable shift amount source; bits [4:0] are used.
- in_shamt  in  5  immediate shift amount.
- in_rd  in  5  destination register index, carried through unchanged.
- sh_inp  out  32  to shifter; held stage-A operand.
- sh_shamt  out  5  to shifter; held stage-A amount.
- sh_dir  out  1  to shifter; 1 = left shift, 0 = right shift.
- sh_out  in  32  shifter result, combinational from sh_*.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_result  out  32  final shift result.
- out_rd  out  5  destination index.
- out_carry  out  1  last bit shifted out.
- out_zero  out  1  out_result == 0.
- out_sign  out  1  out_result[31].
- out_illegal  out  1  opcode was 011 or 111.

## Operation
- Stage A register holds valid_a, operand, amount, dir, the arith flag, rd, carry and illegal. Stage B register holds valid_b and all out_* values.
- Amount is in_shamt for op[2]=0 and in_rt[4:0] for op[2]=1. Direction is left for op[1:0]=00, right otherwise.
- Carry is computed at accept from in_rs with amount n:
  - n=0 gives 0.
  - left gives in_rs[32-n].
  - right gives in_rs[n-1].
- Arithmetic ops (x10) with operand[31]=1: out_result = sh_out | ~(32'hFFFFFFFF >> n). Otherwise out_result = sh_out.
- Illegal op: amount forced to 0 and dir to right, so out_result = in_rs, carry = 0, out_illegal = 1.
- out_zero and out_sign are derived from the final out_result and registered with it.
- Advance rules:
  - B loads from A when valid_a and (!valid_b or out_ready).
  - A loads from input when in_valid and in_ready.
- in_ready = !valid_a | !valid_b | out_ready. This is combinational and has no dependence on in_valid.
- Simultaneous A→B transfer and new accept in the same cycle is legal. It sustains 1 result per cycle.

## Timing
- Latency: an instruction accepted at edge k gives out_valid=1 after edge k+1.
- Outputs are stable while out_valid && !out_ready. No data change is allowed under stall.
- With both stages full and out_ready=0, in_ready=0 and nothing is lost or duplicated.
- Reset values (after any edge with rst=1):
  - valid_a = valid_b = 0.
  - out_valid = 0.
  - out_result, out_rd, out_carry, out_zero, out_sign and out_illegal = 0.
  - sh_inp = 0, sh_shamt = 0, sh_dir = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards both stages. No partial output is ever presented.
- sh_out must settle within the cycle. There is no multicycle path through the shifter.

## Configuration
- SHIFT_ARITH_EN defined: shra/shrav apply the sign fill as above.
- SHIFT_ARITH_EN undefined: 010 and 110 execute as shrl/shrlv, with no sign fill and out_illegal=0. The arith flag register and fill logic are removed.

## Test plan
- Reset, then shll with in_rs=32'h0000_0001, in_shamt=4 → after 2 edges: out_result=32'h10, carry=0, zero=0, sign=0.
- shrav with in_rs=32'h8000_00F0, in_rt=32'h24 (amount 4) → out_result=32'hF800_000F, carry=0. With SHIFT_ARITH_EN undefined → 32'h0800_000F.
- shrl with in_rs=32'h0000_0003, in_shamt=2 → out_result=0, zero=1, carry=1. Amount 0 on any op → result=in_rs, carry=0.
- Back-to-back 8 ops with out_ready=1 → 8 results on 8 consecutive cycles, in order.
- Then hold out_ready=0 for 5 cycles with in_valid=1 → in_ready drops after 2 accepts and out_* stays frozen; release → no loss or duplication.
- Illegal op 011 with in_rs=32'hDEAD_BEEF → out_result=32'hDEAD_BEEF, out_illegal=1. Assert rst with both stages full → out_valid=0 on the next cycle.

Source files
------------

// File: rtl/shift_issue_stage.sv
// Two-stage valid/ready issue stage feeding an external 32-bit logical shifter.
// Optional macro SHIFT_ARITH_EN enables sign fill for shra/shrav.
module shift_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_shamt,
  input  logic [4:0]  in_rd,
  output logic [31:0] sh_inp,
  output logic [4:0]  sh_shamt,
  output logic        sh_dir,
  input  logic [31:0] sh_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_carry,
  output logic        out_zero,
  output logic        out_sign,
  output logic        out_illegal
);

  logic        valid_a, valid_b;
  logic [31:0] a_inp;
  logic [4:0]  a_shamt, a_rd;
  logic        a_dir, a_carry, a_illegal;
`ifdef SHIFT_ARITH_EN
  logic        a_arith;
  logic        dec_arith;
`endif

  logic [4:0]  dec_amt, lidx, ridx;
  logic        dec_dir, dec_ill, dec_carry;
  logic [31:0] res_b;
  logic        a_load, b_load;

  always_comb begin
    dec_ill = (in_op[1:0] == 2'b11);
    dec_amt = in_op[2] ? in_rt[4:0] : in_shamt;
    if (dec_ill) dec_amt = 5'd0;
    dec_dir = (in_op[1:0] == 2'b00);
    // 0 - n wraps to 32 - n for n in 1..31
    lidx = 5'd0 - dec_amt;
    ridx = dec_amt - 5'd1;
    dec_carry = 1'b0;
    if (dec_amt != 5'd0) dec_carry = dec_dir ? in_rs[lidx] : in_rs[ridx];
`ifdef SHIFT_ARITH_EN
    dec_arith = (in_op[1:0] == 2'b10);
`endif
  end

  always_comb begin
    res_b = sh_out;
`ifdef SHIFT_ARITH_EN
    if (a_arith && a_inp[31]) res_b = sh_out | ~(32'hFFFF_FFFF >> a_shamt);
`endif
  end

  assign in_ready = !valid_a || !valid_b || out_ready;
  assign a_load   = in_valid && in_ready;
  assign b_load   = valid_a && (!valid_b || out_ready);

  assign sh_inp    = a_inp;
  assign sh_shamt  = a_shamt;
  assign sh_dir    = a_dir;
  assign out_valid = valid_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_a     <= 1'b0;
      valid_b     <= 1'b0;
      a_inp       <= '0;
      a_shamt     <= '0;
      a_dir       <= 1'b0;
      a_rd        <= '0;
      a_carry     <= 1'b0;
      a_illegal   <= 1'b0;
`ifdef SHIFT_ARITH_EN
      a_arith     <= 1'b0;
`endif
      out_result  <= '0;
      out_rd      <= '0;
      out_carry   <= 1'b0;
      out_zero    <= 1'b0;
      out_sign    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      if (a_load) begin
        valid_a   <= 1'b1;
        a_inp     <= in_rs;
        a_shamt   <= dec_amt;
        a_dir     <= dec_dir;
        a_rd      <= in_rd;
        a_carry   <= dec_carry;
        a_illegal <= dec_ill;
`ifdef SHIFT_ARITH_EN
        a_arith   <= dec_arith;
`endif
      end else if (b_load) begin
        valid_a <= 1'b0;
      end

      // B only changes on a load, so outputs hold steady under stall
      if (b_load) begin
        valid_b     <= 1'b1;
        out_result  <= res_b;
        out_rd      <= a_rd;
        out_carry   <= a_carry;
        out_zero    <= (res_b == 32'd0);
        out_sign    <= res_b[31];
        out_illegal <= a_illegal;
      end else if (out_ready) begin
        valid_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage; the shifter is modelled behaviourally here.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [4:0]  in_shamt = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] sh_inp;
  logic [4:0]  sh_shamt;
  logic        sh_dir;
  logic [31:0] sh_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_carry, out_zero, out_sign, out_illegal;

  always #5 clk = ~clk;

  assign sh_out = sh_dir ? (sh_inp << sh_shamt) : (sh_inp >> sh_shamt);

  shift_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_rd(in_rd),
    .sh_inp(sh_inp), .sh_shamt(sh_shamt), .sh_dir(sh_dir), .sh_out(sh_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_carry(out_carry),
    .out_zero(out_zero), .out_sign(out_sign), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        carry;
    logic        zero;
    logic        sign;
    logic        illegal;
  } exp_t;

`ifdef SHIFT_ARITH_EN
  localparam logic [31:0] EXP_SHRAV = 32'hF800_000F;
`else
  localparam logic [31:0] EXP_SHRAV = 32'h0800_000F;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q[$];
  int   hs_cyc[$];

  // Wide shifts expose the shifted-out bit just beyond the 32-bit window.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic [4:0] shamt, input logic [4:0] rd);
    exp_t e;
    int n;
    logic [63:0] w;
    logic ill, left, arith;
    ill = (op[1:0] == 2'b11);
    n = op[2] ? int'(rt[4:0]) : int'(shamt);
    if (ill) n = 0;
    left = (op[1:0] == 2'b00);
`ifdef SHIFT_ARITH_EN
    arith = (op[1:0] == 2'b10);
`else
    arith = 1'b0;
`endif
    if (left) begin
      w = {32'b0, rs} << n;
      e.result = w[31:0];
      e.carry = w[32];
    end else begin
      w = {rs, 32'b0} >> n;
      if (arith && rs[31]) w = $signed({rs, 32'b0}) >>> n;
      e.result = w[63:32];
      e.carry = w[31];
    end
    e.rd = rd;
    e.zero = (e.result == 32'd0);
    e.sign = e.result[31];
    e.illegal = ill;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, got;
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        got = '{out_result, out_rd, out_carry, out_zero, out_sign, out_illegal};
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra got=%h expected=none", got);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL sb_result got=%h expected=%h", got, e);
          end
        end
        hs_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) q.push_back(model(in_op, in_rs, in_rt, in_shamt, in_rd));
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] sh, input logic [4:0] rd);
    bit ok;
    in_op = op; in_rs = rs; in_rt = rt; in_shamt = sh; in_rd = rd; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) return;
    end
    total++; bad++;
    $display("FAIL send_timeout in_ready=%b expected=1", in_ready);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) return;
      @(posedge clk); #1;
    end
    total++; bad++;
    $display("FAIL drain_timeout pending=%0d expected=0", q.size());
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b expected=1", in_ready); end
    total++; if ({out_result, out_rd, out_carry, out_zero, out_sign, out_illegal} !== 42'd0) begin
      bad++; $display("FAIL rst_out_fields got=%h/%h expected=0", out_result, out_rd); end
    total++; if ({sh_inp, sh_shamt, sh_dir} !== 38'd0) begin
      bad++; $display("FAIL rst_sh got=%h/%h/%b expected=0", sh_inp, sh_shamt, sh_dir); end
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(3'b000, 32'h0000_0001, 32'h0, 5'd4, 5'd3);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b expected=0", out_valid); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b expected=1", out_valid); end
    total++; if ({out_result, out_carry, out_zero, out_sign} !== {32'h10, 3'b000}) begin
      bad++; $display("FAIL lat_shll got=%h c%b z%b s%b expected=10 c0 z0 s0", out_result, out_carry, out_zero, out_sign); end
    drain();
  endtask

  task automatic test_arith();
    send(3'b110, 32'h8000_00F0, 32'h24, 5'd0, 5'd7);
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if ({out_result, out_carry} !== {EXP_SHRAV, 1'b0}) begin
      bad++; $display("FAIL shrav got=%h c%b expected=%h c0", out_result, out_carry, EXP_SHRAV); end
    drain();
  endtask

  task automatic test_zero_amount();
    logic [2:0] ops [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    send(3'b001, 32'h3, 32'h0, 5'd2, 5'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if ({out_result, out_zero, out_carry} !== {32'h0, 2'b11}) begin
      bad++; $display("FAIL shrl_zero got=%h z%b c%b expected=0 z1 c1", out_result, out_zero, out_carry); end
    drain();
    foreach (ops[i]) begin
      send(ops[i], 32'h8000_0001, 32'hFFFF_FFE0, 5'd0, 5'(i));
      in_valid = 1'b0;
      @(posedge clk); #1;
      total++; if ({out_result, out_carry} !== {32'h8000_0001, 1'b0}) begin
        bad++; $display("FAIL amt0_op%0d got=%h c%b expected=80000001 c0", ops[i], out_result, out_carry); end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    hs_cyc.delete();
    for (int i = 0; i < 8; i++)
      send(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), 5'(i));
    in_valid = 1'b0;
    drain();
    total++; if (hs_cyc.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d expected=8", hs_cyc.size()); end
    else begin
      total++; if (hs_cyc[7] - hs_cyc[0] != 7) begin
        bad++; $display("FAIL b2b_span got=%0d expected=7", hs_cyc[7] - hs_cyc[0]); end
    end
  endtask

  task automatic test_stall();
    int accepts = 0;
    bit ok, have_ref = 0;
    logic [36:0] ref_out = '0;
    bit done = 0;
    out_ready = 1'b0;
    in_op = 3'($urandom_range(0, 7)); in_rs = $urandom; in_rt = $urandom; in_shamt = 5'($urandom); in_rd = 5'd20;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ok = in_ready;
      if (out_valid) begin
        if (!have_ref) begin ref_out = {out_result, out_rd}; have_ref = 1; end
        else begin
          total++; if ({out_result, out_rd} !== ref_out) begin
            bad++; $display("FAIL stall_frozen got=%h expected=%h", {out_result, out_rd}, ref_out); end
        end
      end
      @(posedge clk); #1;
      if (ok) begin
        accepts++;
        in_op = 3'($urandom_range(0, 7)); in_rs = $urandom; in_rt = $urandom;
        in_shamt = 5'($urandom); in_rd = 5'(21 + accepts);
      end
    end
    total++; if (accepts != 2) begin bad++; $display("FAIL stall_accepts got=%0d expected=2", accepts); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b expected=0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) done = 1;
    end
    in_valid = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL stall_release got=0 expected=1"); end
    drain();
  endtask

  task automatic test_illegal();
    send(3'b011, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd9);
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if ({out_result, out_illegal, out_carry} !== {32'hDEAD_BEEF, 2'b10}) begin
      bad++; $display("FAIL illegal got=%h i%b c%b expected=deadbeef i1 c0", out_result, out_illegal, out_carry); end
    send(3'b111, 32'h1234_5678, 32'h3, 5'd0, 5'd10);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(3'b001, $urandom, 32'h0, 5'd3, 5'd11);
    send(3'b100, $urandom, 32'h7, 5'd0, 5'd12);
    in_valid = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b10) begin
      bad++; $display("FAIL full_state got=v%b r%b expected=v1 r0", out_valid, in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL rst_mid got=v%b r%b expected=v0 r1", out_valid, in_ready); end
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_ghost got=%b expected=0", out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
    test_zero_amount();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    drain();
    total++; if (q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d expected=0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
